// File: rtl/pipelined_adder_tree_acc.sv
// Pipelined NUM_IN-input adder tree with full-precision levels, followed by a multi-beat
// group accumulator that emits one sum/count/overflow result per group over valid/ready.
module pipelined_adder_tree_acc #(
    parameter  int NUM_IN    = 9,
    parameter  int IN_W      = 16,
    parameter  int SIGNED    = 0,
    parameter  int ACC_W     = 32,
    parameter  int MAX_BEATS = 256,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_IN*IN_W-1:0] in_data,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       out_sum,
    output logic [CNT_W-1:0]       out_beats,
    output logic                   out_overflow
);
    localparam int LV = $clog2(NUM_IN);
    localparam int TW = IN_W + LV;

    function automatic int nodes_at(input int lvl);
        return (NUM_IN + (1 << lvl) - 1) >> lvl;
    endfunction

    logic             w_adv;
    logic [TW-1:0]    w_top;
    logic             w_top_vld;
    logic             w_top_last;
    logic [ACC_W-1:0] w_ext;
    logic [ACC_W-1:0] w_base;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_acc_next;
    logic             w_ovf;
    logic             w_sticky_now;
    logic [CNT_W-1:0] w_cnt_next;

    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_start;
    logic             r_sticky;
    logic [ACC_W-1:0] r_out_sum;
    logic [CNT_W-1:0] r_out_beats;
    logic             r_out_ovf;
    logic             r_out_valid;

    // The whole pipeline moves as one unit: it advances whenever the output slot is free or being drained.
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    generate
        for (genvar l = 0; l <= LV; l++) begin : g_lvl
            localparam int N = nodes_at(l);
            localparam int W = IN_W + l;
            logic [N*W-1:0] w_node;
            logic           w_vld;
            logic           w_last;
            if (l == 0) begin : g_in
                assign w_node = in_data;
                assign w_vld  = in_valid;
                assign w_last = in_last;
            end else begin : g_reg
                localparam int NP = nodes_at(l - 1);
                logic [N*W-1:0] w_sum;
                logic [N*W-1:0] r_node;
                logic           r_vld;
                logic           r_last;
                for (genvar j = 0; j < N; j++) begin : g_node
                    logic [W-2:0] w_a;
                    assign w_a = g_lvl[l-1].w_node[(2*j)*(W-1) +: (W-1)];
                    if (2*j + 1 < NP) begin : g_add
                        logic [W-2:0] w_b;
                        assign w_b = g_lvl[l-1].w_node[(2*j+1)*(W-1) +: (W-1)];
                        if (SIGNED != 0) begin : g_s
                            assign w_sum[j*W +: W] = W'($signed(w_a)) + W'($signed(w_b));
                        end else begin : g_u
                            assign w_sum[j*W +: W] = W'(w_a) + W'(w_b);
                        end
                    end else begin : g_pass
                        if (SIGNED != 0) begin : g_s
                            assign w_sum[j*W +: W] = W'($signed(w_a));
                        end else begin : g_u
                            assign w_sum[j*W +: W] = W'(w_a);
                        end
                    end
                end
                // Tree level register; one bit wider than the level below so no carry is lost.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_vld  <= 1'b0;
                        r_last <= 1'b0;
                        r_node <= '0;
                    end else if (w_adv) begin
                        r_vld  <= g_lvl[l-1].w_vld;
                        r_last <= g_lvl[l-1].w_last;
                        r_node <= w_sum;
                    end
                end
                assign w_node = r_node;
                assign w_vld  = r_vld;
                assign w_last = r_last;
            end
        end

        if (SIGNED != 0) begin : g_ext_s
            assign w_ext = ACC_W'($signed(w_top));
        end else begin : g_ext_u
            assign w_ext = ACC_W'(w_top);
        end
    endgenerate

    assign w_top      = g_lvl[LV].w_node;
    assign w_top_vld  = g_lvl[LV].w_vld;
    assign w_top_last = g_lvl[LV].w_last;

    // Accumulate-stage arithmetic: group restart, overflow detection and saturating beat count.
    always_comb begin
        w_base       = '0;
        w_ovf        = 1'b0;
        w_cnt_next   = r_cnt;
        if (r_start) begin
            w_base = '0;
        end else begin
            w_base = r_acc;
        end
        w_add      = {1'b0, w_base} + {1'b0, w_ext};
        w_acc_next = w_add[ACC_W-1:0];
        if (SIGNED != 0) begin
            w_ovf = (w_base[ACC_W-1] == w_ext[ACC_W-1]) && (w_acc_next[ACC_W-1] != w_base[ACC_W-1]);
        end else begin
            w_ovf = w_add[ACC_W];
        end
        w_sticky_now = (r_start ? 1'b0 : r_sticky) | w_ovf;
        if (r_start) begin
            w_cnt_next = CNT_W'(1);
        end else if (r_cnt == CNT_W'(MAX_BEATS)) begin
            w_cnt_next = r_cnt;
        end else begin
            w_cnt_next = r_cnt + CNT_W'(1);
        end
    end

    // Accumulator state and the held result slot; a completing group may refill the slot as it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_start     <= 1'b1;
            r_sticky    <= 1'b0;
            r_out_sum   <= '0;
            r_out_beats <= '0;
            r_out_ovf   <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_adv) begin
            if (w_top_vld) begin
                r_acc    <= w_acc_next;
                r_cnt    <= w_cnt_next;
                r_sticky <= w_sticky_now;
                r_start  <= w_top_last;
            end
            if (w_top_vld && w_top_last) begin
                r_out_sum   <= w_acc_next;
                r_out_beats <= w_cnt_next;
                r_out_ovf   <= w_sticky_now;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_out_valid;
    assign out_sum      = r_out_sum;
    assign out_beats    = r_out_beats;
    assign out_overflow = r_out_ovf;

endmodule

// File: tb/tb_pipelined_adder_tree_acc.sv
// Scoreboard bench: three configurations (unsigned/32, signed/32, unsigned/20 with beat
// saturation at 3) share one stimulus stream; each has its own reference model and queue.
module tb_pipelined_adder_tree_acc;
    localparam int NI = 9;
    localparam int IW = 16;

    typedef struct {
        longint sum;
        int     beats;
        bit     ovf;
        int     acc_cyc;
        bit     lat;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic [NI*IW-1:0] in_data;
    logic             in_last;
    logic             out_ready;
    logic             in_ready0, in_ready1, in_ready2;
    logic             out_valid0, out_valid1, out_valid2;
    logic [31:0]      out_sum0, out_sum1;
    logic [19:0]      out_sum2;
    logic [8:0]       out_beats0, out_beats1;
    logic [1:0]       out_beats2;
    logic             out_ovf0, out_ovf1, out_ovf2;

    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     stall = 1'b0;
    exp_t   sb[3][$];
    int     m_sgn[3] = '{0, 1, 0};
    int     m_w[3]   = '{32, 32, 20};
    int     m_max[3] = '{256, 256, 3};
    longint m_acc[3];
    bit     m_start[3];
    int     m_cnt[3];
    bit     m_sticky[3];
    bit     held[3];
    longint h_sum[3];
    int     h_beats[3];
    bit     h_ovf[3];

    pipelined_adder_tree_acc #(.NUM_IN(NI), .IN_W(IW), .SIGNED(0), .ACC_W(32), .MAX_BEATS(256)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid0), .out_ready(out_ready), .out_sum(out_sum0),
        .out_beats(out_beats0), .out_overflow(out_ovf0));
    pipelined_adder_tree_acc #(.NUM_IN(NI), .IN_W(IW), .SIGNED(1), .ACC_W(32), .MAX_BEATS(256)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid1), .out_ready(out_ready), .out_sum(out_sum1),
        .out_beats(out_beats1), .out_overflow(out_ovf1));
    pipelined_adder_tree_acc #(.NUM_IN(NI), .IN_W(IW), .SIGNED(0), .ACC_W(20), .MAX_BEATS(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
        .in_last(in_last), .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
        .out_beats(out_beats2), .out_overflow(out_ovf2));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete (obs=timeout exp=finish)");
        $fatal(1);
    end

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: obs=%0d (0x%0h) exp=%0d (0x%0h) t=%0t", tag, obs, obs, exp, exp, $time);
        end
    endtask

    function automatic longint o_sum(input int d);
        case (d)
            0:       return longint'(out_sum0);
            1:       return longint'(out_sum1);
            default: return longint'(out_sum2);
        endcase
    endfunction

    function automatic int o_beats(input int d);
        case (d)
            0:       return int'(out_beats0);
            1:       return int'(out_beats1);
            default: return int'(out_beats2);
        endcase
    endfunction

    function automatic bit o_ovf(input int d);
        case (d)
            0:       return out_ovf0;
            1:       return out_ovf1;
            default: return out_ovf2;
        endcase
    endfunction

    function automatic bit o_vld(input int d);
        case (d)
            0:       return out_valid0;
            1:       return out_valid1;
            default: return out_valid2;
        endcase
    endfunction

    function automatic bit o_rdy(input int d);
        case (d)
            0:       return in_ready0;
            1:       return in_ready1;
            default: return in_ready2;
        endcase
    endfunction

    function automatic logic [NI*IW-1:0] fill(input logic [IW-1:0] v);
        logic [NI*IW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*IW +: IW] = v;
        return r;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            m_acc[d]    = 0;
            m_start[d]  = 1'b1;
            m_cnt[d]    = 0;
            m_sticky[d] = 1'b0;
            sb[d].delete();
        end
    endtask

    // Exact-arithmetic reference: sum the beat, detect range overflow, then wrap to ACC_W.
    task automatic model_beat(input int d, input logic [NI*IW-1:0] data, input bit last, input bit lat);
        longint bs = 0;
        longint m  = longint'(1) << m_w[d];
        longint nx;
        bit     ovf;
        exp_t   e;
        logic [IW-1:0] p;
        for (int k = 0; k < NI; k++) begin
            p = data[k*IW +: IW];
            if (m_sgn[d] != 0) bs += longint'($signed(p));
            else               bs += longint'(p);
        end
        nx = (m_start[d] ? 0 : m_acc[d]) + bs;
        if (m_sgn[d] != 0) ovf = (nx >= m/2) || (nx < -(m/2));
        else               ovf = (nx >= m);
        nx = ((nx % m) + m) % m;
        if (m_sgn[d] != 0 && nx >= m/2) nx -= m;
        m_sticky[d] = (m_start[d] ? 1'b0 : m_sticky[d]) | ovf;
        m_cnt[d]    = m_start[d] ? 1 : ((m_cnt[d] == m_max[d]) ? m_cnt[d] : m_cnt[d] + 1);
        m_acc[d]    = nx;
        m_start[d]  = last;
        if (last) begin
            e.sum = nx & (m - 1); e.beats = m_cnt[d]; e.ovf = m_sticky[d];
            e.acc_cyc = cyc; e.lat = lat;
            sb[d].push_back(e);
        end
    endtask

    // Drive one beat (caller sits just after a falling edge) and hold it until accepted.
    task automatic send(input logic [NI*IW-1:0] data, input bit last, input bit lat);
        int n = 0;
        in_data = data; in_last = last; in_valid = 1'b1;
        while (!(in_ready0 && in_ready1 && in_ready2) && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (n >= 200) begin
            check_val("in_ready_timeout", 0, 1);
        end else begin
            for (int d = 0; d < 3; d++) model_beat(d, data, last, lat);
        end
        @(negedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 100) begin
            @(negedge clk); #1; n++;
        end
        check_val("drain_pending", sb[0].size() + sb[1].size() + sb[2].size(), 0);
    endtask

    task automatic check_idle(input string tag);
        for (int d = 0; d < 3; d++) begin
            check_val({tag, "_valid"}, o_vld(d), 0);
            check_val({tag, "_sum"},   o_sum(d), 0);
            check_val({tag, "_beats"}, o_beats(d), 0);
            check_val({tag, "_ovf"},   o_ovf(d), 0);
        end
    endtask

    // Monitor: sets out_ready from the stall request, pops and compares on each handshake,
    // and checks held outputs and back-pressure while stalled.
    initial begin
        exp_t e;
        out_ready = 1'b0;
        for (int d = 0; d < 3; d++) held[d] = 1'b0;
        forever begin
            @(negedge clk);
            out_ready = !stall;
            if (rst_n) begin
                for (int d = 0; d < 3; d++) begin
                    if (!o_vld(d)) begin
                        held[d] = 1'b0;
                    end else if (!out_ready) begin
                        check_val("in_ready_stall", o_rdy(d), 0);
                        if (held[d]) begin
                            check_val("hold_sum",   o_sum(d),   h_sum[d]);
                            check_val("hold_beats", o_beats(d), h_beats[d]);
                            check_val("hold_ovf",   o_ovf(d),   h_ovf[d]);
                        end
                        held[d] = 1'b1; h_sum[d] = o_sum(d); h_beats[d] = o_beats(d); h_ovf[d] = o_ovf(d);
                    end else begin
                        held[d] = 1'b0;
                        if (sb[d].size() == 0) begin
                            check_val("unexpected_out_valid", 1, 0);
                        end else begin
                            e = sb[d].pop_front();
                            check_val("out_sum",   o_sum(d),   e.sum);
                            check_val("out_beats", o_beats(d), e.beats);
                            check_val("out_ovf",   o_ovf(d),   e.ovf);
                            if (e.lat) check_val("latency", cyc - e.acc_cyc, 5);
                        end
                    end
                end
            end
        end
    end

    initial begin
        logic [NI*IW-1:0] d_seq;
        logic [NI*IW-1:0] d_rnd;
        rst_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk); #1;

        // all-ones products: full-precision tree (no dropped carries), fixed latency
        send(fill(16'hFFFF), 1'b1, 1'b1);
        drain();

        // three-beat group of 1..9
        for (int k = 0; k < NI; k++) d_seq[k*IW +: IW] = 16'(k + 1);
        send(d_seq, 1'b0, 1'b0);
        send(d_seq, 1'b0, 1'b0);
        send(d_seq, 1'b1, 1'b1);
        drain();

        // random single-beat stream with a 10-cycle output stall mid-stream
        fork
            begin
                for (int g = 0; g < 8; g++) begin
                    for (int k = 0; k < NI; k++) d_rnd[k*IW +: IW] = 16'($urandom_range(0, 65535));
                    send(d_rnd, 1'b1, 1'b0);
                end
            end
            begin
                repeat (4) @(posedge clk);
                stall = 1'b1;
                repeat (10) @(posedge clk);
                stall = 1'b0;
            end
        join
        drain();

        // most-negative signed products
        send(fill(16'h8000), 1'b1, 1'b1);
        drain();

        // overflow in the narrow accumulator, then an overflow-free group clears the flag
        send(fill(16'hFFFF), 1'b0, 1'b0);
        send(fill(16'hFFFF), 1'b1, 1'b0);
        send(fill(16'h0001), 1'b1, 1'b0);
        drain();

        // five-beat group: beat count saturates at 3 on the narrow instance
        for (int b = 0; b < 5; b++) send(fill(16'h0001), (b == 4), 1'b0);
        drain();

        // reset in the middle of a group, after its beats have reached the accumulator
        send(fill(16'h0001), 1'b0, 1'b0);
        send(fill(16'h0001), 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle("midgroup_reset");
        model_reset();
        @(negedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        send(fill(16'h0001), 1'b1, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
